tiger_dmem_access: RTL and testbench

Memory-access stage of the Tiger MIPS pipeline, between execute and writeback. Decodes load/store opcodes, runs a single-outstanding data-memory transaction on an Avalon-style master port with wait-request and read-data-valid handshakes, stalls upstream while the transaction is in flight, and aligns and extends load data. Presents a registered result (`MAOut`) with its instruction and control word to writeback.

---
 rtl/tiger_dmem_access_pkg.sv | 66 ++++++
 rtl/tiger_load_align.sv | 31 +++
 rtl/tiger_dmem_access.sv | 164 ++++++++++++++++
 tb/tb_tiger_dmem_access.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tiger_dmem_access_pkg.sv
// Shared constants, state encodings and lane helpers for the Tiger memory-access stage.
package tiger_dmem_access_pkg;

    localparam int CONTROL_WIDTH    = 8;
    localparam int CONTROL_REGWRITE = 0;

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT_DATA} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic size_t access_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    // Big-endian lanes: offset 0 is the most significant byte (enable bit 3).
    function automatic logic [3:0] lane_enable(input size_t sz, input logic [1:0] off);
        case (sz)
            SZ_BYTE: return 4'b1000 >> off;
            SZ_HALF: return off[1] ? 4'b0011 : 4'b1100;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input size_t sz, input logic [31:0] rt);
        case (sz)
            SZ_BYTE: return {4{rt[7:0]}};
            SZ_HALF: return {2{rt[15:0]}};
            default: return rt;
        endcase
    endfunction

endpackage

// File: rtl/tiger_load_align.sv
// Selects the addressed byte/halfword of a big-endian read word and extends it per load opcode.
module tiger_load_align
    import tiger_dmem_access_pkg::*;
(
    input  logic [31:0] read_data,
    input  logic [1:0]  offset,
    input  logic [5:0]  opcode,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = read_data[31:24];
            2'd1:    byte_sel = read_data[23:16];
            2'd2:    byte_sel = read_data[15:8];
            default: byte_sel = read_data[7:0];
        endcase
        half_sel = offset[1] ? read_data[15:0] : read_data[31:16];
        case (opcode)
            OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result = {24'h0, byte_sel};
            OP_LH:   result = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result = {16'h0, half_sel};
            default: result = read_data;
        endcase
    end

endmodule

// File: rtl/tiger_dmem_access.sv
// Tiger MIPS memory-access stage: single-outstanding Avalon-style data access with
// upstream stall, misalignment trapping and registered writeback outputs.
module tiger_dmem_access
    import tiger_dmem_access_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     inValid,
    input  logic [31:0]              instr,
    input  logic [CONTROL_WIDTH-1:0] control,
    input  logic [31:0]              aluResult,
    input  logic [31:0]              storeData,
    output logic                     stall,
    output logic [31:0]              memAddress,
    output logic                     memRead,
    output logic                     memWrite,
    output logic [3:0]               memByteEnable,
    output logic [31:0]              memWriteData,
    input  logic [31:0]              memReadData,
    input  logic                     memWaitRequest,
    input  logic                     memReadDataValid,
    output logic                     outValid,
    output logic [31:0]              outInstr,
    output logic [CONTROL_WIDTH-1:0] outControl,
    output logic [31:0]              MAOut,
    output logic                     addrErr
);

    state_t                   state_q, state_d;
    logic [5:0]               opcode;
    size_t                    size;
    logic                     mem_op;
    logic                     bad_align;
    logic [CONTROL_WIDTH-1:0] control_noreg;

    logic                     pend_load;
    logic [5:0]               pend_op;
    logic [1:0]               pend_offset;
    logic [31:0]              pend_instr;
    logic [CONTROL_WIDTH-1:0] pend_control;
    logic [31:0]              pend_alu;
    logic [31:0]              load_result;

    assign opcode    = instr[31:26];
    assign size      = access_size(opcode);
    assign mem_op    = is_mem_op(opcode);
    assign bad_align = mem_op && misaligned(size, aluResult[1:0]);

    always_comb begin
        control_noreg = control;
        control_noreg[CONTROL_REGWRITE] = 1'b0;
    end

    tiger_load_align u_align (
        .read_data (memReadData),
        .offset    (pend_offset),
        .opcode    (pend_op),
        .result    (load_result)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Stall is released in the cycle a transaction completes so upstream advances in lockstep.
    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inValid && mem_op && !bad_align) begin
                    stall   = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                memRead  = pend_load;
                memWrite = !pend_load;
                stall    = 1'b1;
                if (!memWaitRequest) begin
                    if (pend_load) begin
                        state_d = ST_WAIT_DATA;
                    end else begin
                        stall   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DATA: begin
                stall = 1'b1;
                if (memReadDataValid) begin
                    stall   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_load     <= 1'b0;
            pend_op       <= '0;
            pend_offset   <= '0;
            pend_instr    <= '0;
            pend_control  <= '0;
            pend_alu      <= '0;
            memAddress    <= '0;
            memByteEnable <= '0;
            memWriteData  <= '0;
            outValid      <= 1'b0;
            outInstr      <= '0;
            outControl    <= '0;
            MAOut         <= '0;
            addrErr       <= 1'b0;
        end else begin
            outValid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (inValid && mem_op && !bad_align) begin
                        pend_load     <= is_load_op(opcode);
                        pend_op       <= opcode;
                        pend_offset   <= aluResult[1:0];
                        pend_instr    <= instr;
                        pend_control  <= control;
                        pend_alu      <= aluResult;
                        memAddress    <= {aluResult[31:2], 2'b00};
                        memByteEnable <= lane_enable(size, aluResult[1:0]);
                        memWriteData  <= store_lanes(size, storeData);
                    end else if (inValid) begin
                        outValid   <= 1'b1;
                        outInstr   <= instr;
                        outControl <= bad_align ? control_noreg : control;
                        MAOut      <= aluResult;
                        addrErr    <= bad_align;
                    end
                end
                ST_REQ: begin
                    if (!memWaitRequest && !pend_load) begin
                        outValid   <= 1'b1;
                        outInstr   <= pend_instr;
                        outControl <= pend_control;
                        MAOut      <= pend_alu;
                        addrErr    <= 1'b0;
                    end
                end
                ST_WAIT_DATA: begin
                    if (memReadDataValid) begin
                        outValid   <= 1'b1;
                        outInstr   <= pend_instr;
                        outControl <= pend_control;
                        MAOut      <= load_result;
                        addrErr    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tiger_dmem_access.sv
// Directed, table-driven bench for tiger_dmem_access with a small wait-state bus responder.
module tb_tiger_dmem_access;
    import tiger_dmem_access_pkg::*;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     inValid;
    logic [31:0]              instr;
    logic [CONTROL_WIDTH-1:0] control;
    logic [31:0]              aluResult;
    logic [31:0]              storeData;
    logic                     stall;
    logic [31:0]              memAddress;
    logic                     memRead;
    logic                     memWrite;
    logic [3:0]               memByteEnable;
    logic [31:0]              memWriteData;
    logic [31:0]              memReadData;
    logic                     memWaitRequest;
    logic                     memReadDataValid;
    logic                     outValid;
    logic [31:0]              outInstr;
    logic [CONTROL_WIDTH-1:0] outControl;
    logic [31:0]              MAOut;
    logic                     addrErr;

    int checks   = 0;
    int failures = 0;

    tiger_dmem_access dut (
        .clk              (clk),
        .reset            (reset),
        .inValid          (inValid),
        .instr            (instr),
        .control          (control),
        .aluResult        (aluResult),
        .storeData        (storeData),
        .stall            (stall),
        .memAddress       (memAddress),
        .memRead          (memRead),
        .memWrite         (memWrite),
        .memByteEnable    (memByteEnable),
        .memWriteData     (memWriteData),
        .memReadData      (memReadData),
        .memWaitRequest   (memWaitRequest),
        .memReadDataValid (memReadDataValid),
        .outValid         (outValid),
        .outInstr         (outInstr),
        .outControl       (outControl),
        .MAOut            (MAOut),
        .addrErr          (addrErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] rt;
        logic [31:0] rdata;
        int          waits;
        int          lat;
        bit          isStore;
        bit          expReq;
        logic [31:0] expAddr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expMa;
        bit          expErr;
        int          expOutCyc;
        int          expStalls;
    } vec_t;

    vec_t vecs[15];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one instruction, plays the bus slave with the vector's wait/latency, checks the result.
    task automatic applyStimulus(input vec_t v);
        int acceptCyc = -1;
        int waitCnt   = 0;
        int reqCycles = 0;
        int stalls    = 0;
        int outCyc    = -1;
        bit holdIn    = 1'b1;
        logic [31:0] instrWord;
        instrWord = {v.op, 26'h2A5A5A5};
        @(negedge clk);
        inValid   = 1'b1;
        instr     = instrWord;
        control   = 8'hFF;
        aluResult = v.addr;
        storeData = v.rt;
        for (int cyc = 0; cyc < 40 && outCyc < 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (!holdIn) inValid = 1'b0;
            memWaitRequest   = 1'b0;
            memReadDataValid = 1'b0;
            memReadData      = 32'hDEADBEEF;
            if (outValid) begin
                outCyc = cyc;
                checkOutput({v.name, ".MAOut"}, MAOut, v.expMa);
                checkOutput({v.name, ".addrErr"}, 32'(addrErr), 32'(v.expErr));
                checkOutput({v.name, ".outControl"}, 32'(outControl), v.expErr ? 32'hFE : 32'hFF);
                checkOutput({v.name, ".outInstr"}, outInstr, instrWord);
            end
            if (memRead || memWrite) begin
                reqCycles++;
                checkOutput({v.name, ".memWrite"}, 32'(memWrite), 32'(v.isStore));
                checkOutput({v.name, ".memAddress"}, memAddress, v.expAddr);
                if (v.isStore) begin
                    checkOutput({v.name, ".memByteEnable"}, 32'(memByteEnable), 32'(v.expBe));
                    checkOutput({v.name, ".memWriteData"}, memWriteData, v.expWdata);
                end
                if (waitCnt < v.waits) begin
                    memWaitRequest = 1'b1;
                    waitCnt++;
                end else begin
                    acceptCyc = cyc;
                end
            end
            if (acceptCyc >= 0 && !v.isStore && cyc == acceptCyc + v.lat) begin
                memReadDataValid = 1'b1;
                memReadData      = v.rdata;
            end
            #1;
            if (stall) stalls++;
            else       holdIn = 1'b0;
        end
        if (outCyc < 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s.timeout: no outValid within 40 cycles", v.name);
        end else begin
            checkOutput({v.name, ".outValidCycle"}, 32'(outCyc), 32'(v.expOutCyc));
            checkOutput({v.name, ".stallCycles"}, 32'(stalls), 32'(v.expStalls));
            checkOutput({v.name, ".reqCycles"}, 32'(reqCycles), v.expReq ? 32'(v.waits + 1) : 32'd0);
        end
        @(negedge clk);
        inValid          = 1'b0;
        memReadDataValid = 1'b0;
        memWaitRequest   = 1'b0;
        checkOutput({v.name, ".singlePulse"}, 32'(outValid), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".stall"}, 32'(stall), 32'd0);
        checkOutput({tag, ".memRead"}, 32'(memRead), 32'd0);
        checkOutput({tag, ".memWrite"}, 32'(memWrite), 32'd0);
        checkOutput({tag, ".outValid"}, 32'(outValid), 32'd0);
        checkOutput({tag, ".addrErr"}, 32'(addrErr), 32'd0);
        checkOutput({tag, ".memAddress"}, memAddress, 32'd0);
        checkOutput({tag, ".memByteEnable"}, 32'(memByteEnable), 32'd0);
        checkOutput({tag, ".memWriteData"}, memWriteData, 32'd0);
        checkOutput({tag, ".MAOut"}, MAOut, 32'd0);
        checkOutput({tag, ".outInstr"}, outInstr, 32'd0);
        checkOutput({tag, ".outControl"}, 32'(outControl), 32'd0);
    endtask

    initial begin
        //            name     op     addr          rt            rdata        w  l  st req expAddr       be       wdata         MAOut         err out stalls
        vecs[0]  = '{"ADD",  6'h00, 32'h12345678, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h12345678, 0, 1, 0};
        vecs[1]  = '{"SB",   6'h28, 32'h00000103, 32'h000000AB, 32'h0,        2, 1, 1, 1, 32'h100,     4'b0001, 32'hABABABAB, 32'h00000103, 0, 4, 3};
        vecs[2]  = '{"LB",   6'h20, 32'h00000201, 32'h0,        32'h11803344, 0, 1, 0, 1, 32'h200,     4'b0000, 32'h0,        32'hFFFFFF80, 0, 3, 2};
        vecs[3]  = '{"LBU",  6'h24, 32'h00000201, 32'h0,        32'h11803344, 0, 1, 0, 1, 32'h200,     4'b0000, 32'h0,        32'h00000080, 0, 3, 2};
        vecs[4]  = '{"LH",   6'h21, 32'h00000202, 32'h0,        32'h11803344, 0, 1, 0, 1, 32'h200,     4'b0000, 32'h0,        32'h00003344, 0, 3, 2};
        vecs[5]  = '{"LWmis",6'h23, 32'h00000302, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h00000302, 1, 1, 0};
        vecs[6]  = '{"LWw3", 6'h23, 32'h00000400, 32'h0,        32'hCAFEF00D, 3, 2, 0, 1, 32'h400,     4'b0000, 32'h0,        32'hCAFEF00D, 0, 7, 6};
        vecs[7]  = '{"SH2",  6'h29, 32'h00000502, 32'h1234BEEF, 32'h0,        0, 1, 1, 1, 32'h500,     4'b0011, 32'hBEEFBEEF, 32'h00000502, 0, 2, 1};
        vecs[8]  = '{"SW",   6'h2B, 32'h00000600, 32'h89ABCDEF, 32'h0,        1, 1, 1, 1, 32'h600,     4'b1111, 32'h89ABCDEF, 32'h00000600, 0, 3, 2};
        vecs[9]  = '{"LHU",  6'h25, 32'h00000700, 32'h0,        32'h80017FFF, 0, 1, 0, 1, 32'h700,     4'b0000, 32'h0,        32'h00008001, 0, 3, 2};
        vecs[10] = '{"LH0",  6'h21, 32'h00000700, 32'h0,        32'h80017FFF, 0, 1, 0, 1, 32'h700,     4'b0000, 32'h0,        32'hFFFF8001, 0, 3, 2};
        vecs[11] = '{"SHmis",6'h29, 32'h00000801, 32'h0000FFFF, 32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'h00000801, 1, 1, 0};
        vecs[12] = '{"LB3",  6'h20, 32'h00000903, 32'h0,        32'h11223384, 0, 1, 0, 1, 32'h900,     4'b0000, 32'h0,        32'hFFFFFF84, 0, 3, 2};
        vecs[13] = '{"SB0",  6'h28, 32'h00000100, 32'h0000005A, 32'h0,        0, 1, 1, 1, 32'h100,     4'b1000, 32'h5A5A5A5A, 32'h00000100, 0, 2, 1};
        vecs[14] = '{"ORI",  6'h0D, 32'hFFFF0000, 32'h0,        32'h0,        0, 1, 0, 0, 32'h0,       4'b0000, 32'h0,        32'hFFFF0000, 0, 1, 0};

        reset            = 1'b1;
        inValid          = 1'b0;
        instr            = '0;
        control          = '0;
        aluResult        = '0;
        storeData        = '0;
        memReadData      = '0;
        memWaitRequest   = 1'b0;
        memReadDataValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i]);

        // Reset while a load waits for data, then a stray data-valid must be ignored.
        @(negedge clk);
        inValid   = 1'b1;
        instr     = {6'h23, 26'h0};
        control   = 8'hFF;
        aluResult = 32'h00000A00;
        @(negedge clk);
        checkOutput("rst.memReadReq", 32'(memRead), 32'd1);
        memWaitRequest = 1'b0;
        @(negedge clk);
        checkOutput("rst.noReqInWait", 32'(memRead), 32'd0);
        reset   = 1'b1;
        inValid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkAllZero("rstMid");
        memReadDataValid = 1'b1;
        memReadData      = 32'h12345678;
        #1;
        checkOutput("rst.lateValid.stall", 32'(stall), 32'd0);
        @(negedge clk);
        memReadDataValid = 1'b0;
        checkOutput("rst.lateValid.outValid", 32'(outValid), 32'd0);
        checkOutput("rst.lateValid.MAOut", MAOut, 32'd0);
        applyStimulus(vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
